tone_gen: RTL and testbench

//  Square-wave tone generator fed by the note reader. Takes the one-hot note

---
 rtl/tone_gen.sv | 137 +++++++++++++
 tb/tb_tone_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/tone_gen.sv
// Square-wave tone generator: decodes a one-hot note and octave into an equal-tempered
// half-period, then toggles the audio line every half-period while a valid note is playing.
module tone_gen #(
    parameter int CLK_HZ = 50_000_000,
    parameter int HP_W   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] signal,
    input  logic [2:0]  band,
    input  logic        en,
    output logic        audio,
    output logic        playing,
    output logic [3:0]  note_idx
);

    typedef enum logic {SILENT = 1'b0, TONE = 1'b1} state_t;

    function automatic logic [HP_W-1:0] round_hp(input logic [63:0] f_mhz);
        logic [63:0] num;
        num = 64'(CLK_HZ) * 64'd500;
        return HP_W'((num + f_mhz / 64'd2) / f_mhz);
    endfunction

    // Indexed directly by note number; slots 0 and 13..15 are never selected.
    localparam logic [HP_W-1:0] BASE_HP [16] = '{
        HP_W'(1),
        round_hp(64'd65406),  round_hp(64'd69296),  round_hp(64'd73416),
        round_hp(64'd77782),  round_hp(64'd82407),  round_hp(64'd87307),
        round_hp(64'd92499),  round_hp(64'd97999),  round_hp(64'd103826),
        round_hp(64'd110000), round_hp(64'd116541), round_hp(64'd123471),
        HP_W'(1), HP_W'(1), HP_W'(1)
    };

    logic [15:0]     sig_d, sig_q;
    logic [2:0]      band_d, band_q;
    logic            en_d, en_q;
    state_t          state_d, state_q;
    logic [HP_W-1:0] cnt_d, cnt_q;
    logic [HP_W-1:0] hp_d, hp_q;
    logic [3:0]      note_d, note_q;
    logic [2:0]      band_lat_d, band_lat_q;
    logic            audio_d, audio_q;

    logic [3:0]      note;
    logic            note_valid;
    logic [HP_W-1:0] hp_new;

    always_comb begin
        sig_d  = signal;
        band_d = band;
        en_d   = en;

        note = 4'd0;
        for (int i = 12; i >= 1; i--) begin
            if (sig_q[i]) note = 4'(i);
        end
        note_valid = en_q && (sig_q[12:1] != 12'd0);
        hp_new     = BASE_HP[note] >> band_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        hp_d       = hp_q;
        note_d     = note_q;
        band_lat_d = band_lat_q;
        audio_d    = audio_q;

        case (state_q)
            SILENT: begin
                cnt_d   = '0;
                audio_d = 1'b0;
                note_d  = 4'd0;
                if (note_valid) begin
                    state_d    = TONE;
                    hp_d       = hp_new;
                    note_d     = note;
                    band_lat_d = band_q;
                end
            end
            TONE: begin
                if (!note_valid) begin
                    state_d = SILENT;
                    cnt_d   = '0;
                    audio_d = 1'b0;
                    note_d  = 4'd0;
                end else if (note != note_q || band_q != band_lat_q) begin
                    // New pitch restarts from phase 0 rather than finishing the old half-period.
                    hp_d       = hp_new;
                    note_d     = note;
                    band_lat_d = band_q;
                    cnt_d      = '0;
                    audio_d    = 1'b0;
                end else if (cnt_q == hp_q - HP_W'(1)) begin
                    audio_d = ~audio_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + HP_W'(1);
                end
            end
            default: begin
                state_d = SILENT;
                cnt_d   = '0;
                audio_d = 1'b0;
                note_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q      <= '0;
            band_q     <= '0;
            en_q       <= 1'b0;
            state_q    <= SILENT;
            cnt_q      <= '0;
            hp_q       <= '0;
            note_q     <= '0;
            band_lat_q <= '0;
            audio_q    <= 1'b0;
        end else begin
            sig_q      <= sig_d;
            band_q     <= band_d;
            en_q       <= en_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hp_q       <= hp_d;
            note_q     <= note_d;
            band_lat_q <= band_lat_d;
            audio_q    <= audio_d;
        end
    end

    assign audio    = audio_q;
    assign playing  = (state_q == TONE);
    assign note_idx = note_q;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen, run at CLK_HZ = 5 MHz so every half-period stays short:
// A/band2 hp=5681, C/band0 hp=38223, C/band1 hp=19111, C/band7 hp=298.
module tb_tone_gen;

    localparam int CLK_HZ = 5_000_000;
    localparam int HP_W   = 20;

    localparam int HP_A2 = 5681;
    localparam int HP_C1 = 19111;
    localparam int HP_C7 = 298;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] signal = 16'h0000;
    logic [2:0]  band = 3'd0;
    logic        en = 1'b0;
    logic        audio;
    logic        playing;
    logic [3:0]  note_idx;

    int n_cmp = 0;
    int n_bad = 0;

    tone_gen #(.CLK_HZ(CLK_HZ), .HP_W(HP_W)) dut (
        .clk(clk), .rst(rst), .signal(signal), .band(band), .en(en),
        .audio(audio), .playing(playing), .note_idx(note_idx)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            signal = 16'($urandom);
            band   = 3'($urandom);
            en     = 1'($urandom);
            tick(1);
            n_cmp++; if (audio !== 1'b0) begin n_bad++; $display("FAIL reset_audio[%0d] got %b want 0", i, audio); end
            n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL reset_playing[%0d] got %b want 0", i, playing); end
            n_cmp++; if (note_idx !== 4'd0) begin n_bad++; $display("FAIL reset_note_idx[%0d] got %0d want 0", i, note_idx); end
        end
        signal = 16'h0000; band = 3'd0; en = 1'b0;
        rst = 1'b0;
        tick(2);
        n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL post_reset_playing got %b want 0", playing); end
    endtask

    task automatic test_play_a();
        en = 1'b1; signal = 16'h0400; band = 3'd2;
        tick(2);
        n_cmp++; if (playing !== 1'b1) begin n_bad++; $display("FAIL a_playing got %b want 1", playing); end
        n_cmp++; if (note_idx !== 4'd10) begin n_bad++; $display("FAIL a_note_idx got %0d want 10", note_idx); end
        n_cmp++; if (audio !== 1'b0) begin n_bad++; $display("FAIL a_audio_entry got %b want 0", audio); end
        tick(HP_A2 - 1);
        n_cmp++; if (audio !== 1'b0) begin n_bad++; $display("FAIL a_audio_before_rise got %b want 0", audio); end
        tick(1);
        n_cmp++; if (audio !== 1'b1) begin n_bad++; $display("FAIL a_audio_rise got %b want 1", audio); end
        tick(HP_A2 - 1);
        n_cmp++; if (audio !== 1'b1) begin n_bad++; $display("FAIL a_audio_high_end got %b want 1", audio); end
        tick(1);
        n_cmp++; if (audio !== 1'b0) begin n_bad++; $display("FAIL a_audio_fall got %b want 0", audio); end
        tick(HP_A2);
        n_cmp++; if (audio !== 1'b1) begin n_bad++; $display("FAIL a_audio_second_rise got %b want 1", audio); end
    endtask

    task automatic test_retrigger();
        signal = 16'h0002; band = 3'd0;
        tick(2);
        n_cmp++; if (note_idx !== 4'd1) begin n_bad++; $display("FAIL c0_note_idx got %0d want 1", note_idx); end
        n_cmp++; if (audio !== 1'b0) begin n_bad++; $display("FAIL c0_audio_retrig got %b want 0", audio); end
        tick(1000);
        n_cmp++; if (audio !== 1'b0) begin n_bad++; $display("FAIL c0_audio_long_low got %b want 0", audio); end
        band = 3'd7;
        tick(2);
        n_cmp++; if (playing !== 1'b1) begin n_bad++; $display("FAIL c7_playing got %b want 1", playing); end
        tick(HP_C7 - 1);
        n_cmp++; if (audio !== 1'b0) begin n_bad++; $display("FAIL c7_audio_before_rise got %b want 0", audio); end
        tick(1);
        n_cmp++; if (audio !== 1'b1) begin n_bad++; $display("FAIL c7_audio_rise got %b want 1", audio); end
    endtask

    task automatic test_invalid();
        en = 1'b0;
        tick(2);
        n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL inv_stop_playing got %b want 0", playing); end
        en = 1'b1; signal = 16'h0001;
        tick(3);
        n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL rest_playing got %b want 0", playing); end
        n_cmp++; if (note_idx !== 4'd0) begin n_bad++; $display("FAIL rest_note_idx got %0d want 0", note_idx); end
        n_cmp++; if (audio !== 1'b0) begin n_bad++; $display("FAIL rest_audio got %b want 0", audio); end
        signal = 16'hE000;
        tick(3);
        n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL high_bits_playing got %b want 0", playing); end
        n_cmp++; if (note_idx !== 4'd0) begin n_bad++; $display("FAIL high_bits_note_idx got %0d want 0", note_idx); end
    endtask

    task automatic test_pause();
        en = 1'b1; signal = 16'h0002; band = 3'd7;
        tick(2 + HP_C7);
        n_cmp++; if (audio !== 1'b1) begin n_bad++; $display("FAIL pause_audio_high got %b want 1", audio); end
        en = 1'b0;
        tick(1);
        n_cmp++; if (playing !== 1'b1) begin n_bad++; $display("FAIL pause_playing_1edge got %b want 1", playing); end
        tick(1);
        n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL pause_playing_2edge got %b want 0", playing); end
        n_cmp++; if (audio !== 1'b0) begin n_bad++; $display("FAIL pause_audio got %b want 0", audio); end
        n_cmp++; if (note_idx !== 4'd0) begin n_bad++; $display("FAIL pause_note_idx got %0d want 0", note_idx); end
        en = 1'b1;
        tick(2);
        n_cmp++; if (playing !== 1'b1) begin n_bad++; $display("FAIL resume_playing got %b want 1", playing); end
        tick(HP_C7 - 1);
        n_cmp++; if (audio !== 1'b0) begin n_bad++; $display("FAIL resume_before_rise got %b want 0", audio); end
        tick(1);
        n_cmp++; if (audio !== 1'b1) begin n_bad++; $display("FAIL resume_rise got %b want 1", audio); end
    endtask

    task automatic test_priority();
        en = 1'b0;
        tick(2);
        en = 1'b1; signal = 16'h0402; band = 3'd1;
        tick(2);
        n_cmp++; if (note_idx !== 4'd1) begin n_bad++; $display("FAIL prio_note_idx got %0d want 1", note_idx); end
        tick(HP_C1 - 1);
        n_cmp++; if (audio !== 1'b0) begin n_bad++; $display("FAIL prio_before_rise got %b want 0", audio); end
        tick(1);
        n_cmp++; if (audio !== 1'b1) begin n_bad++; $display("FAIL prio_rise got %b want 1", audio); end
    endtask

    task automatic test_reset_midtone();
        rst = 1'b1;
        tick(1);
        n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL midrst_playing got %b want 0", playing); end
        n_cmp++; if (audio !== 1'b0) begin n_bad++; $display("FAIL midrst_audio got %b want 0", audio); end
        n_cmp++; if (note_idx !== 4'd0) begin n_bad++; $display("FAIL midrst_note_idx got %0d want 0", note_idx); end
        rst = 1'b0;
        tick(2);
        n_cmp++; if (note_idx !== 4'd1) begin n_bad++; $display("FAIL midrst_resume_note got %0d want 1", note_idx); end
    endtask

    initial begin
        test_reset();
        test_play_a();
        test_retrigger();
        test_invalid();
        test_pause();
        test_priority();
        test_reset_midtone();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
